// File: rtl/bank_burst_seq_if.sv
// bank_burst_seq_if: command/data bus between host, bank_burst_seq and the Bank.
//   Host side   : act/pre/rd/wr commands, row_addr, col_addr, dq_in -> sequencer
//                 dq_out, rd_valid, busy, row_open, cmd_err, evict  <- sequencer
//   Bank side   : bank_rd_o_wr, bank_row, bank_column, bank_dqin    <- sequencer
//                 bank_dqout                                        -> sequencer
//   slave modport is the sequencer view; master is the host + Bank view.
interface bank_burst_seq_if #(
    parameter int DEVICE_WIDTH = 4,
    parameter int COLWIDTH     = 10,
    parameter int CHWIDTH      = 5,
    parameter int RAWIDTH      = 16
);
    logic                    act;
    logic                    pre;
    logic                    rd;
    logic                    wr;
    logic [RAWIDTH-1:0]      row_addr;
    logic [COLWIDTH-1:0]     col_addr;
    logic [DEVICE_WIDTH-1:0] dq_in;
    logic [DEVICE_WIDTH-1:0] dq_out;
    logic                    rd_valid;
    logic                    busy;
    logic                    row_open;
    logic                    cmd_err;
    logic                    evict;
    logic                    bank_rd_o_wr;
    logic [CHWIDTH-1:0]      bank_row;
    logic [COLWIDTH-1:0]     bank_column;
    logic [DEVICE_WIDTH-1:0] bank_dqin;
    logic [DEVICE_WIDTH-1:0] bank_dqout;

    modport slave (
        input  act, pre, rd, wr, row_addr, col_addr, dq_in, bank_dqout,
        output dq_out, rd_valid, busy, row_open, cmd_err, evict,
               bank_rd_o_wr, bank_row, bank_column, bank_dqin
    );

    modport master (
        output act, pre, rd, wr, row_addr, col_addr, dq_in, bank_dqout,
        input  dq_out, rd_valid, busy, row_open, cmd_err, evict,
               bank_rd_o_wr, bank_row, bank_column, bank_dqin
    );
endinterface

// File: rtl/bank_burst_seq.sv
// bank_burst_seq: maps real rows onto Bank slots and expands RD/WR into BL-beat wrapped bursts.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : bank_burst_seq_if.slave (host commands/data in, status out, Bank address/data)
module bank_burst_seq #(
    parameter int DEVICE_WIDTH = 4,
    parameter int COLWIDTH     = 10,
    parameter int CHWIDTH      = 5,
    parameter int RAWIDTH      = 16,
    parameter int BL           = 8
) (
    input logic               clk,
    input logic               rst_n,
    bank_burst_seq_if.slave   bus
);
    localparam int CHROWS = 2 ** CHWIDTH;
    localparam int LB     = (BL > 1) ? $clog2(BL) : 1;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_RD     = 2'd2;
    localparam logic [1:0] S_WR     = 2'd3;
    localparam logic [COLWIDTH-1:0] LO_MASK = COLWIDTH'(BL - 1);
    logic [1:0]          r_state;
    logic [CHROWS-1:0]   r_valid;
    logic [RAWIDTH-1:0]  r_tag [CHROWS];
    logic [CHWIDTH-1:0]  r_alloc;
    logic [CHWIDTH-1:0]  r_slot;
    logic [COLWIDTH-1:0] r_col;
    logic [LB-1:0]       r_beat;
    logic                r_we;
    logic                r_rd_valid;
    logic                r_cmd_err;
    logic                r_evict;
    logic [1:0]          w_next;
    logic [2:0]          w_ncmd;
    logic                w_busy;
    logic                w_last;
    logic                w_illegal;
    logic                w_ok;
    logic                w_act;
    logic                w_rw;
    logic                w_hit;
    logic [CHWIDTH-1:0]  w_hit_idx;
    logic [COLWIDTH-1:0] w_col_inc;
    assign w_ncmd    = 3'(bus.act) + 3'(bus.pre) + 3'(bus.rd) + 3'(bus.wr);
    assign w_busy    = r_state[1];
    assign w_last    = r_beat == LB'(BL - 1);
    assign w_illegal = (w_ncmd != 3'd0) && ((w_ncmd > 3'd1) || w_busy ||
                       (bus.act && r_state == S_ACTIVE) ||
                       ((bus.pre || bus.rd || bus.wr) && r_state == S_IDLE));
    assign w_ok      = (w_ncmd != 3'd0) && !w_illegal;
    assign w_act     = w_ok && bus.act;
    assign w_rw      = w_ok && (bus.rd || bus.wr);
    // Only the low log2(BL) bits advance, so the burst wraps inside its aligned block.
    assign w_col_inc = (r_col & ~LO_MASK) | ((r_col + COLWIDTH'(1)) & LO_MASK);
    assign w_next    = w_act              ? S_ACTIVE :
                       (w_ok && bus.pre)  ? S_IDLE   :
                       (w_ok && bus.rd)   ? S_RD     :
                       (w_ok && bus.wr)   ? S_WR     :
                       (w_busy && w_last) ? S_ACTIVE : r_state;
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = 0; i < CHROWS; i++)
            if (r_valid[i] && r_tag[i] == bus.row_addr) begin
                w_hit     = 1'b1;
                w_hit_idx = CHWIDTH'(i);
            end
    end
    // Tags need no reset: valid bits gate every lookup.
    always_ff @(posedge clk)
        if (w_act && !w_hit) r_tag[r_alloc] <= bus.row_addr;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_alloc    <= '0;
            r_slot     <= '0;
            r_col      <= '0;
            r_beat     <= '0;
            r_we       <= 1'b0;
            r_rd_valid <= 1'b0;
            r_cmd_err  <= 1'b0;
            r_evict    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_we       <= w_next == S_WR;
            // Bank read data lags the address by one cycle.
            r_rd_valid <= r_state == S_RD;
            r_cmd_err  <= w_illegal;
            r_evict    <= w_act && !w_hit && r_valid[r_alloc];
            if (w_act) begin
                r_slot <= w_hit ? w_hit_idx : r_alloc;
                if (!w_hit) begin
                    r_valid[r_alloc] <= 1'b1;
                    r_alloc          <= r_alloc + CHWIDTH'(1);
                end
            end
            if (w_rw) begin
                r_col  <= bus.col_addr;
                r_beat <= '0;
            end else if (w_busy && !w_last) begin
                r_col  <= w_col_inc;
                r_beat <= r_beat + LB'(1);
            end
        end
    end
    assign bus.busy         = w_busy;
    assign bus.row_open     = r_state != S_IDLE;
    assign bus.rd_valid     = r_rd_valid;
    assign bus.cmd_err      = r_cmd_err;
    assign bus.evict        = r_evict;
    assign bus.bank_rd_o_wr = r_we;
    assign bus.bank_row     = r_slot;
    assign bus.bank_column  = r_col;
    assign bus.bank_dqin    = bus.dq_in;
    assign bus.dq_out       = bus.bank_dqout;
endmodule

// File: doc/bank_burst_seq.md
# bank_burst_seq

Command-side sequencer sitting directly upstream of the Bank storage model. It accepts per-bank ACT/RD/WR/PRE commands carrying real row and column addresses. It maps each real row onto one of the CHROWS full-row slots the Bank physically holds, and expands every RD/WR into a BL-beat burst of column addresses and data strobes on the Bank's `rd_o_wr`/`row`/`column`/`dqin` ports. For reads it returns `dqout` with a valid flag.

## Interface
- DEVICE_WIDTH, 4: data bits per column location; matches the Bank.
- COLWIDTH, 10: column address width; matches the Bank.
- CHWIDTH, 5: slot index width; CHROWS = 2**CHWIDTH slots.
- RAWIDTH, 16: real row address width carried by ACT.
- BL, 8: burst length, a power of two, 2 to 2**COLWIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- act  in  1  activate command; row_addr is valid.
- pre  in  1  precharge command.
- rd  in  1  read burst command; col_addr is valid.
- wr  in  1  write burst command; col_addr is valid.
- row_addr  in  RAWIDTH  real row for ACT.
- col_addr  in  COLWIDTH  starting column for RD/WR.
- dq_in  in  DEVICE_WIDTH  write data, one beat per cycle.
- dq_out  out  DEVICE_WIDTH  read data.
- rd_valid  out  1  dq_out holds a read beat.
- busy  out  1  a burst is in progress.
- row_open  out  1  a row is active.
- cmd_err  out  1  one-cycle pulse: an illegal command was dropped.
- evict  out  1  one-cycle pulse: ACT reused a valid slot.
- bank_rd_o_wr  out  1  to Bank: 0 = read, 1 = write.
- bank_row  out  CHWIDTH  to Bank: slot index.
- bank_column  out  COLWIDTH  to Bank: column.
- bank_dqin  out  DEVICE_WIDTH  to Bank: write data.
- bank_dqout  in  DEVICE_WIDTH  from Bank: read data. Registered-read SRAM, one-cycle latency.

## Operation
- States: IDLE (no row open), ACTIVE (row open), RD_BURST, WR_BURST.
- Row map: CHROWS entries, each holding {valid, tag[RAWIDTH]}, plus a round-robin allocation pointer alloc_ptr[CHWIDTH].
- ACT in IDLE:
  - Search all valid tags for row_addr.
  - Hit: the open slot is the hit index.
  - Miss: the open slot is alloc_ptr. Write the tag and set valid. Pulse evict if that entry was already valid. alloc_ptr increments mod CHROWS.
  - Next state is ACTIVE.
- PRE in ACTIVE: go to IDLE. Map entries stay valid, so the row contents survive for a later hit.
- RD/WR in ACTIVE: latch col_addr and go to RD_BURST or WR_BURST for BL beats. Return to ACTIVE after the last beat.
- Beat k column:
  - Upper bits: {col_addr[COLWIDTH-1:log2(BL)]}.
  - Low log2(BL) bits: (col_addr[log2(BL)-1:0] + k) mod BL.
  - The burst wraps within its BL-aligned block and never crosses into the next block.
- Illegal commands are ignored, pulse cmd_err, and leave state unchanged:
  - more than one of act/pre/rd/wr high in the same cycle;
  - ACT while a row is open;
  - PRE, RD or WR in IDLE;
  - any command while busy.
- Output values:
  - bank_rd_o_wr is 1 only during WR_BURST beat cycles, 0 otherwise.
  - bank_dqin = dq_in (combinational passthrough).
  - dq_out = bank_dqout (passthrough).
  - bank_row holds the open slot. bank_column holds the current beat column, or the last value when not bursting.
- Reset (rst_n low at a clock edge):
  - state IDLE; all map entries invalid; alloc_ptr 0.
  - all outputs 0.
  - A burst in progress is aborted: no bank_rd_o_wr=1 in the cycle after reset is sampled, and the read pipeline is flushed (rd_valid 0).

## Timing
- Commands are sampled at rising edge t. Bank-side outputs are registered.
- ACT at t: row_open=1 and bank_row=slot from cycle t+1. evict pulses in cycle t+1.
- RD at t:
  - busy=1 in cycles t+1..t+BL.
  - Beat k address is driven in cycle t+1+k.
  - rd_valid=1 in cycles t+2..t+BL+1, with dq_out carrying beat k in cycle t+2+k.
- WR at t:
  - Beat k address is driven in cycle t+1+k with bank_rd_o_wr=1.
  - The host presents beat k on dq_in in cycle t+1+k.
- Next command: the earliest is at edge t+BL+1, where busy is already 0. A command at edge t+BL, where busy=1, is illegal.
- cmd_err is registered and asserts in cycle t+1 for an illegal command at t.
- Back-to-back read then write: rd_valid of the read tail may overlap the first write beat; this is legal.

## Test plan
- Reset, then ACT row 0x1234, WR col 0x005 with data 1..8 (BL=8), PRE, ACT 0x1234, RD col 0x005 → slot 0 on both ACTs; columns 5,6,7,0,1,2,3,4; read returns 1..8 in the same order; rd_valid high for exactly 8 cycles starting two cycles after RD.
- Issue CHROWS+1 distinct ACT/PRE pairs → slots 0..31 then 0 again; evict pulses only on the 33rd ACT; re-ACT of the first row misses and allocates slot 1.
- RD in IDLE; ACT while open; WR at edge t+BL during a burst; act+rd together → each gives exactly one cmd_err pulse, with no change to state, busy or bank outputs.
- rst_n low at beat 3 of a WR burst → bank_rd_o_wr=0 from the next cycle; row_open=0; a subsequent ACT of the same row misses and allocates slot 0.
- RD col 0x3FF, BL=8 → columns 0x3FF, 0x3F8..0x3FE; no access outside 0x3F8–0x3FF.
